// File: rtl/coin_return_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_return_pkg
// Purpose  : Shared types and job-step helper for the coin return sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package coin_return_pkg;

  // Sequencer states: one state per solenoid pulse, plus the shared off-time.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VEND = 3'd1,
    ST_DIME = 3'd2,
    ST_NICK = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Pulse timer phases.
  typedef enum logic [1:0] {
    PH_OFF = 2'd0,
    PH_ON  = 2'd1,
    PH_GAP = 2'd2
  } phase_t;

  // Work still owed for the current job.
  typedef struct packed {
    logic       vend;
    logic [2:0] nick_req;
    logic [1:0] dime_req;
  } job_t;

  // Nickels paid out in place of one dime when the dime tube is empty.
  localparam int DIME_SUB_NICKELS = 2;

  // Outcome of one scheduling decision.
  typedef struct packed {
    logic   start;     // a pulse begins this edge
    state_t act;       // which solenoid pulses
    job_t   job;       // work remaining after this decision
    logic   dec_nick;  // nickel leaves the tube
    logic   dec_dime;  // dime leaves the tube
    logic   fault;     // needed coin unavailable, job abandoned
  } step_t;

  // Picks the next actuation in vend -> dimes -> nickels order. An empty dime
  // tube converts every outstanding dime into nickels at once when at least
  // two nickels are on hand; the nickels then go out in order.
  function automatic step_t next_step(input job_t job, input logic dime_avail,
                                      input logic nick_ge2, input logic nick_avail);
    step_t s;
    job_t  j;
    s     = '0;
    s.act = ST_IDLE;
    j     = job;
    if (j.vend) begin
      s.start = 1'b1;
      s.act   = ST_VEND;
      j.vend  = 1'b0;
    end else if (j.dime_req != 2'd0 && dime_avail) begin
      s.start    = 1'b1;
      s.act      = ST_DIME;
      s.dec_dime = 1'b1;
      j.dime_req = j.dime_req - 2'd1;
    end else if (j.dime_req != 2'd0 && nick_ge2) begin
      j.nick_req = j.nick_req + 3'(DIME_SUB_NICKELS) * {1'b0, j.dime_req};
      j.dime_req = 2'd0;
      s.start    = 1'b1;
      s.act      = ST_NICK;
      s.dec_nick = 1'b1;
      j.nick_req = j.nick_req - 3'd1;
    end else if (j.dime_req != 2'd0) begin
      s.fault = 1'b1;
      j       = '0;
    end else if (j.nick_req != 3'd0 && nick_avail) begin
      s.start    = 1'b1;
      s.act      = ST_NICK;
      s.dec_nick = 1'b1;
      j.nick_req = j.nick_req - 3'd1;
    end else if (j.nick_req != 3'd0) begin
      s.fault = 1'b1;
      j       = '0;
    end
    s.job = j;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_return_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module   : solenoid_timer
// Purpose  : Times one solenoid pulse (PULSE_CYCLES on) followed by the
//            mandatory off-time (GAP_CYCLES). A start restarts the on phase.
// Revision : 1.0 - initial release
// ============================================================================
module solenoid_timer
  import coin_return_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic on,
  output logic on_last,
  output logic done
);

  localparam int c_MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_CW         = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_PULSE_LAST = c_CW'(PULSE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP_CYCLES - 1);

  phase_t            r_phase;
  phase_t            w_phase_next;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_next;

  assign on      = (r_phase == PH_ON);
  assign on_last = on && (r_cnt == c_PULSE_LAST);
  assign done    = (r_phase == PH_GAP) && (r_cnt == c_GAP_LAST);

  // Phase and cycle counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase <= PH_OFF;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Advance through on -> gap -> off; start has priority so back-to-back
  // pulses need no idle cycle after the gap.
  always_comb begin
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt;
    if (start) begin
      w_phase_next = PH_ON;
      w_cnt_next   = '0;
    end else begin
      case (r_phase)
        PH_ON: begin
          if (on_last) begin
            w_phase_next = PH_GAP;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + c_CW'(1);
          end
        end
        PH_GAP: begin
          if (done) begin
            w_phase_next = PH_OFF;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + c_CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_return_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : coin_return_sequencer
// Purpose  : Drives vend and coin-ejector solenoids one timed pulse at a time
//            from dispenser request pulses; tracks tube inventory, substitutes
//            nickels for missing dimes and flags shortfalls.
//            Optional build macro COIN_RETURN_STATS_EN adds vend_total and
//            coins_paid counters.
// Revision : 1.0 - initial release
// ============================================================================
module coin_return_sequencer
  import coin_return_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8,
  parameter int INIT_NICKELS = 20,
  parameter int INIT_DIMES   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dis,
  input  logic             rn,
  input  logic             rd,
  input  logic             rtd,
  input  logic             refill_n,
  input  logic             refill_d,
  output logic             sol_vend,
  output logic             sol_nickel,
  output logic             sol_dime,
  output logic             busy,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic             low_change,
  output logic             overrun,
  output logic             fault
`ifdef COIN_RETURN_STATS_EN
  ,
  output logic [15:0]      vend_total,
  output logic [15:0]      coins_paid
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;
  job_t             r_job;
  job_t             w_job_next;
  job_t             w_cap_job;
  step_t            w_cur_step;
  step_t            w_cap_step;
  step_t            w_sel;
  logic             w_take;
  logic             w_start;
  logic             w_dec_n;
  logic             w_dec_d;
  logic             w_fault_set;
  logic             w_overrun_set;
  logic             w_req;
  logic             w_tmr_on;
  logic             w_tmr_on_last;
  logic             w_tmr_done;
  logic [CNT_W-1:0] r_nickel;
  logic [CNT_W-1:0] r_dime;
  logic             r_fault;
  logic             r_overrun;

  assign w_req     = dis | rn | rd | rtd;
  assign w_cap_job = '{vend: dis, nick_req: {2'b00, rn}, dime_req: {rtd, rd}};

  assign w_cur_step = next_step(r_job, (r_dime != '0), (r_nickel >= CNT_W'(DIME_SUB_NICKELS)),
                                (r_nickel != '0));
  assign w_cap_step = next_step(w_cap_job, (r_dime != '0), (r_nickel >= CNT_W'(DIME_SUB_NICKELS)),
                                (r_nickel != '0));

  solenoid_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .on      (w_tmr_on),
    .on_last (w_tmr_on_last),
    .done    (w_tmr_done)
  );

  // Sequencer state and outstanding job.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_job   <= '0;
    end else begin
      r_state <= w_state_next;
      r_job   <= w_job_next;
    end
  end

  // Next-state decode; a job ending at a gap edge may hand over directly to a
  // request arriving on that same edge.
  always_comb begin
    w_state_next  = r_state;
    w_job_next    = r_job;
    w_sel         = w_cur_step;
    w_take        = 1'b0;
    w_fault_set   = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_take = 1'b1;
          w_sel  = w_cap_step;
        end
      end
      ST_VEND, ST_DIME, ST_NICK: begin
        w_overrun_set = w_req;
        if (w_tmr_on_last) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tmr_done) begin
          if (w_cur_step.start) begin
            w_take        = 1'b1;
            w_overrun_set = w_req;
          end else begin
            w_fault_set  = w_cur_step.fault;
            w_state_next = ST_IDLE;
            w_job_next   = '0;
            if (w_req) begin
              w_take = 1'b1;
              w_sel  = w_cap_step;
            end
          end
        end else begin
          w_overrun_set = w_req;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_job_next   = '0;
      end
    endcase
    if (w_take) begin
      w_fault_set = w_fault_set | w_sel.fault;
      if (w_sel.start) begin
        w_state_next = w_sel.act;
        w_job_next   = w_sel.job;
      end else begin
        w_state_next = ST_IDLE;
        w_job_next   = '0;
      end
    end
  end

  assign w_start = w_take & w_sel.start;
  assign w_dec_n = w_take & w_sel.dec_nick;
  assign w_dec_d = w_take & w_sel.dec_dime;

  // Net inventory change: refill and payout in the same cycle cancel out.
  function automatic logic [CNT_W-1:0] f_next_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec) begin
      return (cnt == c_CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      return cnt - CNT_W'(1);
    end
    return cnt;
  endfunction

  // Tube inventories, decremented on the edge that starts an ejector pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_nickel <= CNT_W'(INIT_NICKELS);
      r_dime   <= CNT_W'(INIT_DIMES);
    end else begin
      r_nickel <= f_next_cnt(r_nickel, refill_n, w_dec_n);
      r_dime   <= f_next_cnt(r_dime, refill_d, w_dec_d);
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fault   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_fault   <= r_fault | w_fault_set;
      r_overrun <= r_overrun | w_overrun_set;
    end
  end

`ifdef COIN_RETURN_STATS_EN
  // Saturating counts of vend and ejector pulses started.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vend_total <= '0;
      coins_paid <= '0;
    end else if (w_start) begin
      if (w_sel.act == ST_VEND) begin
        if (vend_total != 16'hFFFF) vend_total <= vend_total + 16'd1;
      end else begin
        if (coins_paid != 16'hFFFF) coins_paid <= coins_paid + 16'd1;
      end
    end
  end
`endif

  assign sol_vend   = (r_state == ST_VEND) & w_tmr_on;
  assign sol_dime   = (r_state == ST_DIME) & w_tmr_on;
  assign sol_nickel = (r_state == ST_NICK) & w_tmr_on;
  assign busy       = (r_state != ST_IDLE);
  assign nickel_cnt = r_nickel;
  assign dime_cnt   = r_dime;
  assign low_change = (r_dime == '0) && (r_nickel < CNT_W'(2));
  assign fault      = r_fault;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_coin_return_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_return_sequencer
// Purpose  : Self-checking bench for coin_return_sequencer: directed scenarios
//            plus randomized traffic against a job-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_return_sequencer;

  localparam int P    = 4;
  localparam int G    = 2;
  localparam int W    = 8;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dis = 1'b0, rn = 1'b0, rd = 1'b0, rtd = 1'b0;
  logic refill_n = 1'b0, refill_d = 1'b0;
  logic sol_vend, sol_nickel, sol_dime, busy, low_change, overrun, fault;
  logic [W-1:0] nickel_cnt, dime_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coin_return_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .CNT_W        (W),
    .INIT_NICKELS (20),
    .INIT_DIMES   (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dis        (dis),
    .rn         (rn),
    .rd         (rd),
    .rtd        (rtd),
    .refill_n   (refill_n),
    .refill_d   (refill_d),
    .sol_vend   (sol_vend),
    .sol_nickel (sol_nickel),
    .sol_dime   (sol_dime),
    .busy       (busy),
    .nickel_cnt (nickel_cnt),
    .dime_cnt   (dime_cnt),
    .low_change (low_change),
    .overrun    (overrun),
    .fault      (fault)
  );

  // Job-level model: pending work counts, the current actuation and how many
  // cycles of it (pulse + gap) remain.
  bit m_busy, m_fault, m_overrun;
  int m_act;   // 1 vend, 2 dime, 3 nickel
  int m_t;
  int m_vend, m_dimes, m_nicks, m_nc, m_dc, m_dn, m_dd;

  task automatic m_reset();
    m_busy = 0; m_fault = 0; m_overrun = 0; m_act = 0; m_t = 0;
    m_vend = 0; m_dimes = 0; m_nicks = 0; m_nc = 20; m_dc = 20;
  endtask

  task automatic m_start(input int a);
    m_act = a; m_t = P + G; m_busy = 1;
  endtask

  task automatic m_kill();
    m_fault = 1; m_vend = 0; m_dimes = 0; m_nicks = 0; m_busy = 0;
  endtask

  task automatic m_pick();
    m_busy = 0;
    if (m_vend != 0) begin
      m_vend = 0;
      m_start(1);
    end else begin
      while (m_dimes > 0 && m_dc == 0 && m_nc >= 2) begin
        m_dimes--;
        m_nicks += 2;
      end
      if (m_dimes > 0) begin
        if (m_dc > 0) begin m_dimes--; m_dd++; m_start(2); end
        else m_kill();
      end else if (m_nicks > 0) begin
        if (m_nc > 0) begin m_nicks--; m_dn++; m_start(3); end
        else m_kill();
      end
    end
  endtask

  task automatic model_step(input bit d, input bit n, input bit dm, input bit td,
                            input bit fn, input bit fd, input bit rst);
    bit free;
    int v;
    if (!rst) begin
      m_reset();
      return;
    end
    m_dn = 0; m_dd = 0;
    free = !m_busy;
    if (m_busy) begin
      m_t--;
      if (m_t == 0) begin
        m_pick();
        free = !m_busy;
      end
    end
    if (d | n | dm | td) begin
      if (free) begin
        m_vend = d; m_nicks = n; m_dimes = dm + 2 * td;
        m_pick();
      end else begin
        m_overrun = 1;
      end
    end
    v = m_nc + fn - m_dn; m_nc = (v > MAXC) ? MAXC : v;
    v = m_dc + fd - m_dd; m_dc = (v > MAXC) ? MAXC : v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("sol_vend",   sol_vend,   32'(m_busy && m_act == 1 && m_t > G));
    chk("sol_dime",   sol_dime,   32'(m_busy && m_act == 2 && m_t > G));
    chk("sol_nickel", sol_nickel, 32'(m_busy && m_act == 3 && m_t > G));
    chk("busy",       busy,       32'(m_busy));
    chk("nickel_cnt", nickel_cnt, 32'(m_nc));
    chk("dime_cnt",   dime_cnt,   32'(m_dc));
    chk("low_change", low_change, 32'(m_dc == 0 && m_nc < 2));
    chk("overrun",    overrun,    32'(m_overrun));
    chk("fault",      fault,      32'(m_fault));
  endtask

  task automatic cycle(input bit d, input bit n, input bit dm, input bit td,
                       input bit fn, input bit fd, input bit rst);
    dis = d; rn = n; rd = dm; rtd = td; refill_n = fn; refill_d = fd; reset = rst;
    @(posedge clk);
    model_step(d, n, dm, td, fn, fd, rst);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic req(input bit d, input bit n, input bit dm, input bit td);
    cycle(d, n, dm, td, 0, 0, 1);
  endtask

  initial begin
    int nb, nv, nn, nd;
    m_reset();

    // Reset state.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("reset_nickels", nickel_cnt, 32'd20);
    chk("reset_dimes", dime_cnt, 32'd20);
    chk("reset_busy", busy, 32'd0);

    // Vend only: 4 cycles on, 6 busy, inventory untouched.
    req(1, 0, 0, 0);
    nb = busy; nv = sol_vend;
    for (int i = 0; i < 10; i++) begin idle(1); nb += busy; nv += sol_vend; end
    chk("dis_busy_cycles", nb, 32'd6);
    chk("dis_vend_cycles", nv, 32'd4);
    chk("dis_nickels", nickel_cnt, 32'd20);
    chk("dis_dimes", dime_cnt, 32'd20);

    // Vend plus two dimes: 18 busy cycles, no nickel pulse.
    req(1, 0, 0, 1);
    nb = busy; nd = sol_dime; nn = sol_nickel;
    for (int i = 0; i < 20; i++) begin idle(1); nb += busy; nd += sol_dime; nn += sol_nickel; end
    chk("vrtd_busy_cycles", nb, 32'd18);
    chk("vrtd_dime_cycles", nd, 32'd8);
    chk("vrtd_nickel_cycles", nn, 32'd0);
    chk("vrtd_dimes", dime_cnt, 32'd18);

    // Empty the dime tube, then a dime return becomes two nickels.
    for (int k = 0; k < 9; k++) begin req(0, 0, 0, 1); idle(13); end
    chk("drain_dimes", dime_cnt, 32'd0);
    req(0, 0, 1, 0);
    nn = sol_nickel; nd = sol_dime;
    for (int i = 0; i < 14; i++) begin idle(1); nn += sol_nickel; nd += sol_dime; end
    chk("sub_nickel_cycles", nn, 32'd8);
    chk("sub_dime_cycles", nd, 32'd0);
    chk("sub_nickels", nickel_cnt, 32'd18);
    chk("sub_fault", fault, 32'd0);

    // One nickel left and no dimes: a dime return faults with no pulse.
    for (int k = 0; k < 17; k++) begin req(0, 1, 0, 0); idle(7); end
    chk("one_nickel", nickel_cnt, 32'd1);
    chk("low_change_set", low_change, 32'd1);
    req(0, 0, 1, 0);
    nn = sol_nickel + sol_dime;
    for (int i = 0; i < 5; i++) begin idle(1); nn += sol_nickel + sol_dime; end
    chk("short_pulses", nn, 32'd0);
    chk("short_fault", fault, 32'd1);
    chk("short_busy", busy, 32'd0);
    chk("short_nickels", nickel_cnt, 32'd1);
    idle(3);
    chk("fault_sticky", fault, 32'd1);

    // Refill coinciding with payout; request while busy sets overrun.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 1);
    chk("refill_net_dimes", dime_cnt, 32'd20);
    idle(2);
    req(0, 1, 0, 0);
    idle(8);
    chk("overrun_set", overrun, 32'd1);
    chk("overrun_nickels", nickel_cnt, 32'd20);

    // Reset in the middle of a dime pulse.
    cycle(0, 0, 0, 0, 0, 0, 0);
    req(1, 0, 1, 1);
    idle(4);
    req(0, 1, 0, 0);
    idle(2);
    chk("midjob_dime_on", sol_dime, 32'd1);
    chk("midjob_dimes", dime_cnt, 32'd19);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("abort_sols", {sol_vend, sol_dime, sol_nickel}, 32'd0);
    chk("abort_dimes", dime_cnt, 32'd20);
    chk("abort_flags", {overrun, fault, busy}, 32'd0);

    // Saturation of both tubes.
    for (int i = 0; i < 240; i++) cycle(0, 0, 0, 0, 1, 1, 1);
    chk("sat_nickels", nickel_cnt, 32'd255);
    chk("sat_dimes", dime_cnt, 32'd255);
    cycle(0, 0, 1, 0, 0, 1, 1);
    idle(10);
    chk("sat_net_dimes", dime_cnt, 32'd255);

    // Randomized traffic: sparse refills first (tubes drain), then heavy.
    for (int k = 0; k < 3000; k++) begin
      int rf;
      rf = (k < 1500) ? 29 : 3;
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, rf) == 0, $urandom_range(0, rf) == 0,
            $urandom_range(0, 599) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
